// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Optional statistics outputs are enabled with RF_ARB_STATS_EN.
package rf_arb_pkg;

    localparam int DEF_DATA_WIDTH = 20;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH      = 2;
    localparam int DEF_MAX_WAIT   = 4;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } arb_state_t;

    function automatic logic [2**DEF_ADDR_WIDTH-1:0] onehot_addr(input logic [DEF_ADDR_WIDTH-1:0] addr);
        onehot_addr       = '0;
        onehot_addr[addr] = 1'b1;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Circular queue of pending side writes {address, data}.
// Exposes per-slot valid bits and addresses so the owner can build a hazard mask.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                push,
    input  logic [ADDR_WIDTH-1:0]               pushAddress,
    input  logic [DATA_WIDTH-1:0]               pushData,
    input  logic                                pop,
    output logic [ADDR_WIDTH-1:0]               headAddress,
    output logic [DATA_WIDTH-1:0]               headData,
    output logic [PTR_W:0]                      count,
    output logic [DEPTH-1:0]                    entryValid,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    entryAddress
);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrMem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] dataMem;
    logic [PTR_W-1:0]                 wrPtr;
    logic [PTR_W-1:0]                 rdPtr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
            addrMem    <= '0;
        end else begin
            if (pop) begin
                rdPtr             <= rdPtr + 1'b1;
                entryValid[rdPtr] <= 1'b0;
            end
            if (push) begin
                wrPtr             <= wrPtr + 1'b1;
                entryValid[wrPtr] <= 1'b1;
                addrMem[wrPtr]    <= pushAddress;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            dataMem[wrPtr] <= pushData;
        end
    end

    assign headAddress  = addrMem[rdPtr];
    assign headData     = dataMem[rdPtr];
    assign entryAddress = addrMem;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between write-back and a queued side requester.
// Define RF_ARB_STATS_EN to add sideGrantCount/forceCount statistics outputs.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wbEnable,
    input  logic [ADDR_WIDTH-1:0]    wbAddress,
    input  logic [DATA_WIDTH-1:0]    wbData,
    input  logic                     sideValid,
    output logic                     sideReady,
    input  logic [ADDR_WIDTH-1:0]    sideAddress,
    input  logic [DATA_WIDTH-1:0]    sideData,
    output logic                     rfWriteEnable,
    output logic [ADDR_WIDTH-1:0]    rfWriteAddress,
    output logic [DATA_WIDTH-1:0]    rfWriteData,
    output logic                     stallPipe,
`ifdef RF_ARB_STATS_EN
    output logic [15:0]              sideGrantCount,
    output logic [15:0]              forceCount,
`endif
    output logic [2**ADDR_WIDTH-1:0] pendingMask
);

    localparam int COUNT_W = $clog2(DEPTH) + 1;
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);

    arb_state_t                       state, nextState;
    logic [WAIT_W-1:0]                waitCount;
    logic [COUNT_W-1:0]               count;
    logic [DEPTH-1:0]                 entryValid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] entryAddress;
    logic [ADDR_WIDTH-1:0]            headAddress;
    logic [DATA_WIDTH-1:0]            headData;
    logic                             push;
    logic                             headGrant;

    assign sideReady = (count != COUNT_W'(DEPTH));
    assign push      = sideValid && sideReady;
    assign stallPipe = (state == FORCE);

    rf_arb_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) sideQueue (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .pushAddress  (sideAddress),
        .pushData     (sideData),
        .pop          (headGrant),
        .headAddress  (headAddress),
        .headData     (headData),
        .count        (count),
        .entryValid   (entryValid),
        .entryAddress (entryAddress)
    );

    // Port mux is gated by reset so every output reads zero while reset is held.
    always_comb begin
        headGrant      = 1'b0;
        rfWriteEnable  = 1'b0;
        rfWriteAddress = '0;
        rfWriteData    = '0;
        if (reset) begin
            if (state == FORCE || (state == PEND && !wbEnable)) begin
                headGrant      = 1'b1;
                rfWriteEnable  = 1'b1;
                rfWriteAddress = headAddress;
                rfWriteData    = headData;
            end else if (wbEnable) begin
                rfWriteEnable  = 1'b1;
                rfWriteAddress = wbAddress;
                rfWriteData    = wbData;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (push) nextState = PEND;
            PEND: begin
                if (!headGrant && waitCount == WAIT_W'(MAX_WAIT - 1)) begin
                    nextState = FORCE;
                end else if (headGrant && count == COUNT_W'(1) && !push) begin
                    nextState = IDLE;
                end
            end
            FORCE: nextState = (count == COUNT_W'(1) && !push) ? IDLE : PEND;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            waitCount <= '0;
        end else begin
            state <= nextState;
            if (headGrant || count == '0) begin
                waitCount <= '0;
            end else if (waitCount != WAIT_W'(MAX_WAIT)) begin
                waitCount <= waitCount + 1'b1;
            end
        end
    end

    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                pendingMask = pendingMask | onehot_addr(entryAddress[i]);
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sideGrantCount <= '0;
            forceCount     <= '0;
        end else begin
            if (headGrant) sideGrantCount <= sideGrantCount + 16'd1;
            if (state == FORCE) forceCount <= forceCount + 16'd1;
        end
    end
`endif

endmodule
